// File: rtl/slot_scheduler.sv
// Falling-character slot table for a typing game: one sequencer serialises frame
// advances, keyboard hits and spawns, touching at most one slot per cycle.
module slot_scheduler #(
  parameter int unsigned SLOTS      = 16,
  parameter logic [9:0]  BOTTOM     = 10'd480,
  parameter logic [7:0]  MISS_LIMIT = 8'd10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic                     spawn_req,
  input  logic [7:0]               spawn_ascii,
  input  logic [9:0]               spawn_x,
  input  logic [2:0]               spawn_speed,
  output logic                     spawn_ack,
  output logic                     spawn_ok,
  input  logic                     hit_req,
  input  logic [7:0]               hit_ascii,
  output logic                     hit_ack,
  output logic                     hit_ok,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [7:0]               rd_ascii,
  output logic [9:0]               rd_x,
  output logic [9:0]               rd_y,
  output logic                     miss,
  output logic [15:0]              score,
  output logic [7:0]               miss_cnt,
  output logic                     gameover,
  output logic                     busy
);

  localparam int unsigned   IW   = $clog2(SLOTS);
  localparam logic [IW-1:0] LAST = IW'(SLOTS - 1);

  typedef enum logic [2:0] {IDLE, ADVANCE, HIT_SCAN, HIT_DONE, SPAWN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick_pend_q, tick_pend_d;
  logic          found_q, found_d;
  logic [IW-1:0] best_q, best_d;
  logic [9:0]    best_y_q, best_y_d;
  logic [15:0]   score_q, score_d;
  logic [7:0]    miss_cnt_q, miss_cnt_d;
  logic          gameover_q, gameover_d;

  logic          valid_q [SLOTS];
  logic          valid_d [SLOTS];
  logic [7:0]    ascii_q [SLOTS];
  logic [7:0]    ascii_d [SLOTS];
  logic [9:0]    x_q     [SLOTS];
  logic [9:0]    x_d     [SLOTS];
  logic [9:0]    y_q     [SLOTS];
  logic [9:0]    y_d     [SLOTS];
  logic [2:0]    speed_q [SLOTS];
  logic [2:0]    speed_d [SLOTS];

  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [10:0]   adv_sum;
  logic          adv_miss;
  logic          tick_req;

  // Lowest-index empty slot, used only by SPAWN.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // The sum is 11 bits wide so a character close to BOTTOM cannot wrap back to the top.
  assign adv_sum  = {1'b0, y_q[idx_q]} + {8'b0, speed_q[idx_q]};
  assign adv_miss = (state_q == ADVANCE) && valid_q[idx_q] && (adv_sum >= {1'b0, BOTTOM});
  assign tick_req = (tick_pend_q | frame_tick) & ~gameover_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tick_pend_d = tick_req;
    found_d     = found_q;
    best_d      = best_q;
    best_y_d    = best_y_q;
    score_d     = score_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    ascii_d     = ascii_q;
    x_d         = x_q;
    y_d         = y_q;
    speed_d     = speed_q;

    case (state_q)
      IDLE: begin
        if (tick_req) begin
          state_d     = ADVANCE;
          idx_d       = '0;
          tick_pend_d = 1'b0;
        end else if (hit_req) begin
          state_d  = HIT_SCAN;
          idx_d    = '0;
          found_d  = 1'b0;
          best_d   = '0;
          best_y_d = '0;
        end else if (spawn_req) begin
          state_d = SPAWN;
        end
      end
      ADVANCE: begin
        if (valid_q[idx_q]) begin
          y_d[idx_q] = adv_sum[9:0];
          if (adv_miss) begin
            valid_d[idx_q] = 1'b0;
            if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
          end
        end
        if (idx_q == LAST) state_d = IDLE;
        else               idx_d   = idx_q + IW'(1);
      end
      HIT_SCAN: begin
        // Strict comparison keeps the lowest index on equal heights.
        if (valid_q[idx_q] && (ascii_q[idx_q] == hit_ascii) &&
            (!found_q || (y_q[idx_q] > best_y_q))) begin
          found_d  = 1'b1;
          best_d   = idx_q;
          best_y_d = y_q[idx_q];
        end
        if (idx_q == LAST) state_d = HIT_DONE;
        else               idx_d   = idx_q + IW'(1);
      end
      HIT_DONE: begin
        state_d = IDLE;
        if (found_q && !gameover_q) begin
          valid_d[best_q] = 1'b0;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end
      end
      SPAWN: begin
        state_d = IDLE;
        if (free_found && !gameover_q) begin
          valid_d[free_idx] = 1'b1;
          ascii_d[free_idx] = spawn_ascii;
          x_d[free_idx]     = spawn_x;
          y_d[free_idx]     = 10'd0;
          speed_d[free_idx] = (spawn_speed == 3'd0) ? 3'd1 : spawn_speed;
        end
      end
      default: state_d = IDLE;
    endcase

    gameover_d = gameover_q | (miss_cnt_d >= MISS_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tick_pend_q <= 1'b0;
      found_q     <= 1'b0;
      best_q      <= '0;
      best_y_q    <= '0;
      score_q     <= '0;
      miss_cnt_q  <= '0;
      gameover_q  <= 1'b0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        valid_q[i] <= 1'b0;
        ascii_q[i] <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        speed_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tick_pend_q <= tick_pend_d;
      found_q     <= found_d;
      best_q      <= best_d;
      best_y_q    <= best_y_d;
      score_q     <= score_d;
      miss_cnt_q  <= miss_cnt_d;
      gameover_q  <= gameover_d;
      valid_q     <= valid_d;
      ascii_q     <= ascii_d;
      x_q         <= x_d;
      y_q         <= y_d;
      speed_q     <= speed_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign hit_ack   = (state_q == HIT_DONE);
  assign hit_ok    = hit_ack & found_q & ~gameover_q;
  assign spawn_ack = (state_q == SPAWN);
  assign spawn_ok  = spawn_ack & free_found & ~gameover_q;
  assign miss      = adv_miss;
  assign score     = score_q;
  assign miss_cnt  = miss_cnt_q;
  assign gameover  = gameover_q;
  assign rd_valid  = valid_q[rd_idx];
  assign rd_ascii  = ascii_q[rd_idx];
  assign rd_x      = x_q[rd_idx];
  assign rd_y      = y_q[rd_idx];

endmodule

// File: tb/tb_slot_scheduler.sv
// Bench for slot_scheduler: a transaction-level game model predicts ack results into
// queues that a monitor pops on each ack; table, counters and latencies are checked directly.
module tb_slot_scheduler;
  localparam int SLOTS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, spawn_req, hit_req;
  logic [7:0] spawn_ascii, hit_ascii;
  logic [9:0] spawn_x;
  logic [2:0] spawn_speed;
  logic       spawn_ack, spawn_ok, hit_ack, hit_ok;
  logic [3:0] rd_idx;
  logic       rd_valid;
  logic [7:0] rd_ascii;
  logic [9:0] rd_x, rd_y;
  logic       miss, gameover, busy;
  logic [15:0] score;
  logic [7:0] miss_cnt;

  slot_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .spawn_req(spawn_req), .spawn_ascii(spawn_ascii), .spawn_x(spawn_x),
    .spawn_speed(spawn_speed), .spawn_ack(spawn_ack), .spawn_ok(spawn_ok),
    .hit_req(hit_req), .hit_ascii(hit_ascii), .hit_ack(hit_ack), .hit_ok(hit_ok),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ascii(rd_ascii), .rd_x(rd_x), .rd_y(rd_y),
    .miss(miss), .score(score), .miss_cnt(miss_cnt), .gameover(gameover), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit spawnQ[$];
  bit hitQ[$];
  int missSeen = 0;

  bit mValid[SLOTS];
  int mAscii[SLOTS], mX[SLOTS], mY[SLOTS], mSpeed[SLOTS];
  int mScore, mMissCnt;
  bit mGameover;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Monitor: every ack must match the oldest prediction for its channel.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (spawn_ack) begin
        if (spawnQ.size() == 0) checkOutput("spawn_unexpected_ack", 1, 0);
        else checkOutput("spawn_ok", spawn_ok, spawnQ.pop_front());
      end
      if (hit_ack) begin
        if (hitQ.size() == 0) checkOutput("hit_unexpected_ack", 1, 0);
        else checkOutput("hit_ok", hit_ok, hitQ.pop_front());
      end
      if (miss) missSeen++;
    end
  end

  task automatic modelClear();
    for (int i = 0; i < SLOTS; i++) begin
      mValid[i] = 0; mAscii[i] = 0; mX[i] = 0; mY[i] = 0; mSpeed[i] = 0;
    end
    mScore = 0; mMissCnt = 0; mGameover = 0;
  endtask

  task automatic modelAdvance();
    int s;
    if (mGameover) return;
    for (int i = 0; i < SLOTS; i++) begin
      if (mValid[i]) begin
        s = mY[i] + mSpeed[i];
        if (s >= 480) begin
          mValid[i] = 0;
          if (mMissCnt < 255) mMissCnt++;
        end else mY[i] = s;
      end
    end
    if (mMissCnt >= 10) mGameover = 1;
  endtask

  task automatic modelHit(input int a, output bit ok);
    int best = -1;
    ok = 0;
    if (mGameover) return;
    for (int i = 0; i < SLOTS; i++)
      if (mValid[i] && mAscii[i] == a && (best < 0 || mY[i] > mY[best])) best = i;
    if (best >= 0) begin
      mValid[best] = 0;
      ok = 1;
      if (mScore < 65535) mScore++;
    end
  endtask

  task automatic modelSpawn(input int a, input int x, input int s, output bit ok);
    ok = 0;
    if (mGameover) return;
    for (int i = 0; i < SLOTS; i++) begin
      if (!mValid[i]) begin
        mValid[i] = 1; mAscii[i] = a; mX[i] = x; mY[i] = 0;
        mSpeed[i] = (s == 0) ? 1 : s;
        ok = 1;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input int dummy);
    frame_tick = 0; spawn_req = 0; hit_req = 0;
    spawn_ascii = 0; spawn_x = 0; spawn_speed = 0; hit_ascii = 0; rd_idx = 0;
  endtask

  task automatic doReset();
    rst_n = 0;
    applyStimulus(0);
    spawnQ.delete(); hitQ.delete();
    modelClear();
    missSeen = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic doSpawn(input int a, input int x, input int s);
    bit ok;
    int n = 0;
    modelSpawn(a, x, s, ok);
    spawnQ.push_back(ok);
    spawn_req = 1; spawn_ascii = 8'(a); spawn_x = 10'(x); spawn_speed = 3'(s);
    do begin @(negedge clk); n++; end while (!spawn_ack && n < 50);
    checkOutput("spawn_latency", n, 1);
    spawn_req = 0;
    @(negedge clk);
  endtask

  task automatic doHit(input int a);
    bit ok;
    int n = 0;
    modelHit(a, ok);
    hitQ.push_back(ok);
    hit_req = 1; hit_ascii = 8'(a);
    do begin @(negedge clk); n++; end while (!hit_ack && n < 60);
    checkOutput("hit_latency", n, SLOTS + 1);
    hit_req = 0;
    @(negedge clk);
  endtask

  task automatic doTick();
    int n = 0;
    int t = 0;
    int expN = mGameover ? 0 : SLOTS;
    modelAdvance();
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    while (busy && t < 40) begin n++; t++; @(negedge clk); end
    checkOutput("advance_cycles", n, expN);
  endtask

  task automatic checkTable();
    for (int i = 0; i < SLOTS; i++) begin
      rd_idx = 4'(i);
      #1;
      checkOutput($sformatf("rd_valid[%0d]", i), rd_valid, mValid[i]);
      if (mValid[i]) begin
        checkOutput($sformatf("rd_ascii[%0d]", i), rd_ascii, mAscii[i]);
        checkOutput($sformatf("rd_x[%0d]", i), rd_x, mX[i]);
        checkOutput($sformatf("rd_y[%0d]", i), rd_y, mY[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok1, ok2;
    int hitT, spawnT;
    rst_n = 0;
    applyStimulus(0);
    modelClear();
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_score", score, 0);
    checkOutput("reset_miss_cnt", miss_cnt, 0);
    checkOutput("reset_gameover", gameover, 0);
    checkOutput("reset_acks", {spawn_ack, spawn_ok, hit_ack, hit_ok, miss}, 0);
    checkOutput("reset_rd_valid", rd_valid, 0);
    doReset();

    // Single character falls 4 px per frame.
    doSpawn("A", 100, 4);
    checkTable();
    repeat (10) doTick();
    rd_idx = 0; #1;
    checkOutput("A_y_after_10", rd_y, 40);
    @(negedge clk);

    // Hit picks the lowest B on screen.
    doSpawn("B", 200, 2);
    doSpawn("B", 300, 5);
    repeat (4) doTick();
    rd_idx = 2; #1;
    checkOutput("B_fast_y", rd_y, 20);
    @(negedge clk);
    doHit("B");
    checkOutput("score_after_B", score, 1);
    checkTable();

    // Equal heights: lowest index wins; unknown character misses.
    doSpawn("C", 10, 3);
    doSpawn("C", 20, 3);
    doHit("C");
    doHit("Z");
    checkOutput("score_after_C", score, mScore);
    checkTable();

    // Fill the table, then overflow.
    for (int i = 0; i < 13; i++) doSpawn(97 + i, 10 * i, i % 8);
    doSpawn("!", 1, 1);
    checkTable();
    doTick();
    checkTable();

    // Bottom boundary with speed 7: 476 survives, 483 misses.
    doReset();
    doSpawn("S", 5, 7);
    repeat (68) doTick();
    rd_idx = 0; #1;
    checkOutput("S_valid_68", rd_valid, 1);
    checkOutput("S_y_68", rd_y, 476);
    @(negedge clk);
    doTick();
    rd_idx = 0; #1;
    checkOutput("S_valid_69", rd_valid, 0);
    checkOutput("miss_cnt_69", miss_cnt, 1);
    checkOutput("miss_pulses_69", missSeen, 1);
    @(negedge clk);

    // Simultaneous tick/hit/spawn with a latched and a dropped extra tick.
    doReset();
    doSpawn("D", 50, 3);
    modelAdvance();
    modelAdvance();
    modelHit("D", ok1);
    hitQ.push_back(ok1);
    modelSpawn("E", 60, 1, ok2);
    spawnQ.push_back(ok2);
    frame_tick = 1; hit_req = 1; hit_ascii = "D";
    spawn_req = 1; spawn_ascii = "E"; spawn_x = 60; spawn_speed = 1;
    hitT = -1; spawnT = -1;
    for (int t = 1; t <= 120 && spawnT < 0; t++) begin
      @(negedge clk);
      if (t == 1 || t == 4 || t == 7) frame_tick = 0;
      if (t == 3 || t == 6) frame_tick = 1;
      if (hit_ack && hitT < 0) begin hitT = t; hit_req = 0; end
      if (spawn_ack) begin spawnT = t; spawn_req = 0; end
    end
    checkOutput("prio_hit_ack_cycle", hitT, 51);
    checkOutput("prio_spawn_ack_cycle", spawnT, 53);
    @(negedge clk);
    checkOutput("prio_score", score, 1);
    checkTable();

    // Reset in the middle of a hit scan: no ack may follow.
    doReset();
    doSpawn("H", 7, 2);
    hit_req = 1; hit_ascii = "H";
    repeat (5) @(negedge clk);
    checkOutput("scan_busy", busy, 1);
    rst_n = 0;
    #1;
    checkOutput("scan_abort_busy", busy, 0);
    checkOutput("scan_abort_ack", hit_ack, 0);
    hit_req = 0;
    spawnQ.delete(); hitQ.delete();
    modelClear();
    @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    checkOutput("scan_abort_score", score, 0);

    // Ten misses end the game.
    doReset();
    for (int i = 0; i < 10; i++) doSpawn(48 + i, 30 * i, 7);
    doSpawn("Q", 400, 1);
    repeat (69) doTick();
    checkOutput("go_gameover", gameover, 1);
    checkOutput("go_miss_cnt", miss_cnt, 10);
    checkOutput("go_miss_pulses", missSeen, 10);
    doSpawn("R", 9, 2);
    doHit("Q");
    doTick();
    checkOutput("go_score", score, 0);
    checkTable();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    checkOutput("go_reset_gameover", gameover, 0);
    checkOutput("go_reset_miss_cnt", miss_cnt, 0);
    rd_idx = 10; #1;
    checkOutput("go_reset_rd_valid", rd_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    checkOutput("spawnQ_leftover", spawnQ.size(), 0);
    checkOutput("hitQ_leftover", hitQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
